tlbrd_unit: RTL and testbench

- Sequencer for the TLBRD instruction, sitting between commit and the TLB-related CSRs (TLBELO0/TLBELO1/TLBEHI/ASID/TLBIDX).
- On a request it reads the TLB entry selected by TLBIDX.Index from the registered TLB array and captures its fields.
- It then issues a single-cycle TLBRD_en write strobe that the CSR registers consume.
- For an invalid or out-of-range entry it drives zero fields with NE=1.

---
 rtl/tlbrd_unit.sv | 137 +++++++++++++
 tb/tb_tlbrd_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlbrd_unit.sv
// rtl/tlbrd_unit.sv - TLBRD sequencer: reads one TLB entry and strobes it into the TLB CSRs.
module tlbrd_unit #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlbrd_req,
  input  logic             flush,
  input  logic [IDX_W-1:0] tlbidx_index,
  output logic             tlb_rd_en,
  output logic [IDX_W-1:0] tlb_rd_addr,
  input  logic             tlb_e,
  input  logic [18:0]      tlb_vppn,
  input  logic [5:0]       tlb_ps,
  input  logic [9:0]       tlb_asid,
  input  logic             tlb_g,
  input  logic [19:0]      tlb_ppn0,
  input  logic [5:0]       tlb_flags0,
  input  logic [19:0]      tlb_ppn1,
  input  logic [5:0]       tlb_flags1,
  output logic             TLBRD_en,
  output logic [19:0]      TLB_PPN_0,
  output logic [5:0]       TLB_flags_0,
  output logic             TLB_G_0,
  output logic [19:0]      TLB_PPN_1,
  output logic [5:0]       TLB_flags_1,
  output logic             TLB_G_1,
  output logic [18:0]      TLB_VPPN,
  output logic [5:0]       TLB_PS,
  output logic [9:0]       TLB_ASID,
  output logic             TLB_NE,
  output logic             tlbrd_busy,
  output logic             tlbrd_done
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WB} state_t;

  typedef struct packed {
    logic [19:0] ppn0;
    logic [5:0]  flags0;
    logic [19:0] ppn1;
    logic [5:0]  flags1;
    logic        g;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        ne;
  } fld_t;

  // One extra bit so TLB_NUM == 2**IDX_W is representable.
  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(TLB_NUM);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  fld_t             fld_q, fld_d;
  logic             accept;
  logic             wb_fire;
  logic             entry_ok;

  assign entry_ok = tlb_e && ({1'b0, idx_q} < NUM_W);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fld_d   = fld_q;
    accept  = 1'b0;
    wb_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tlbrd_req && !flush && !rst) begin
          accept  = 1'b1;
          idx_d   = tlbidx_index;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
          if (entry_ok) begin
            fld_d.ppn0   = tlb_ppn0;
            fld_d.flags0 = tlb_flags0;
            fld_d.ppn1   = tlb_ppn1;
            fld_d.flags1 = tlb_flags1;
            fld_d.g      = tlb_g;
            fld_d.vppn   = tlb_vppn;
            fld_d.ps     = tlb_ps;
            fld_d.asid   = tlb_asid;
            fld_d.ne     = 1'b0;
          end else begin
            fld_d    = '0;
            fld_d.ne = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        wb_fire = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fld_q   <= fld_d;
    end
  end

  // Address goes out combinationally in the accept cycle so data lands in RD.
  assign tlb_rd_en   = accept;
  assign tlb_rd_addr = accept ? tlbidx_index : idx_q;

  assign TLBRD_en    = wb_fire;
  assign tlbrd_done  = wb_fire;
  assign tlbrd_busy  = (state_q != S_IDLE);

  assign TLB_PPN_0   = fld_q.ppn0;
  assign TLB_flags_0 = fld_q.flags0;
  assign TLB_G_0     = fld_q.g;
  assign TLB_PPN_1   = fld_q.ppn1;
  assign TLB_flags_1 = fld_q.flags1;
  assign TLB_G_1     = fld_q.g;
  assign TLB_VPPN    = fld_q.vppn;
  assign TLB_PS      = fld_q.ps;
  assign TLB_ASID    = fld_q.asid;
  assign TLB_NE      = fld_q.ne;

endmodule

// File: tb/tb_tlbrd_unit.sv
// tb/tb_tlbrd_unit.sv - scoreboard bench for tlbrd_unit (TLB_NUM=12 to reach out-of-range indices).
module tb_tlbrd_unit;
  localparam int TLB_NUM = 12;
  localparam int IDX_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tlbrd_req;
  logic             flush;
  logic [IDX_W-1:0] tlbidx_index;
  logic             tlb_rd_en;
  logic [IDX_W-1:0] tlb_rd_addr;
  logic             tlb_e;
  logic [18:0]      tlb_vppn;
  logic [5:0]       tlb_ps;
  logic [9:0]       tlb_asid;
  logic             tlb_g;
  logic [19:0]      tlb_ppn0;
  logic [5:0]       tlb_flags0;
  logic [19:0]      tlb_ppn1;
  logic [5:0]       tlb_flags1;
  logic             TLBRD_en;
  logic [19:0]      TLB_PPN_0;
  logic [5:0]       TLB_flags_0;
  logic             TLB_G_0;
  logic [19:0]      TLB_PPN_1;
  logic [5:0]       TLB_flags_1;
  logic             TLB_G_1;
  logic [18:0]      TLB_VPPN;
  logic [5:0]       TLB_PS;
  logic [9:0]       TLB_ASID;
  logic             TLB_NE;
  logic             tlbrd_busy;
  logic             tlbrd_done;

  tlbrd_unit #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .tlbrd_req(tlbrd_req), .flush(flush),
    .tlbidx_index(tlbidx_index), .tlb_rd_en(tlb_rd_en), .tlb_rd_addr(tlb_rd_addr),
    .tlb_e(tlb_e), .tlb_vppn(tlb_vppn), .tlb_ps(tlb_ps), .tlb_asid(tlb_asid),
    .tlb_g(tlb_g), .tlb_ppn0(tlb_ppn0), .tlb_flags0(tlb_flags0),
    .tlb_ppn1(tlb_ppn1), .tlb_flags1(tlb_flags1), .TLBRD_en(TLBRD_en),
    .TLB_PPN_0(TLB_PPN_0), .TLB_flags_0(TLB_flags_0), .TLB_G_0(TLB_G_0),
    .TLB_PPN_1(TLB_PPN_1), .TLB_flags_1(TLB_flags_1), .TLB_G_1(TLB_G_1),
    .TLB_VPPN(TLB_VPPN), .TLB_PS(TLB_PS), .TLB_ASID(TLB_ASID), .TLB_NE(TLB_NE),
    .tlbrd_busy(tlbrd_busy), .tlbrd_done(tlbrd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] ppn0;
    logic [5:0]  flags0;
    logic [19:0] ppn1;
    logic [5:0]  flags1;
    logic        g;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        ne;
  } exp_t;

  // TLB array model, 2**IDX_W slots so out-of-range indices still return data.
  logic        m_e     [16];
  logic [18:0] m_vppn  [16];
  logic [5:0]  m_ps    [16];
  logic [9:0]  m_asid  [16];
  logic        m_g     [16];
  logic [19:0] m_ppn0  [16];
  logic [5:0]  m_flags0[16];
  logic [19:0] m_ppn1  [16];
  logic [5:0]  m_flags1[16];

  always @(posedge clk) begin
    if (tlb_rd_en) begin
      tlb_e      <= m_e[tlb_rd_addr];
      tlb_vppn   <= m_vppn[tlb_rd_addr];
      tlb_ps     <= m_ps[tlb_rd_addr];
      tlb_asid   <= m_asid[tlb_rd_addr];
      tlb_g      <= m_g[tlb_rd_addr];
      tlb_ppn0   <= m_ppn0[tlb_rd_addr];
      tlb_flags0 <= m_flags0[tlb_rd_addr];
      tlb_ppn1   <= m_ppn1[tlb_rd_addr];
      tlb_flags1 <= m_flags1[tlb_rd_addr];
    end
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_cnt  = 0;
  int   pulses   = 0;
  exp_t exp_q[$];
  exp_t shadow;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t make_exp(input int idx);
    exp_t e;
    e = '{default: '0};
    if (m_e[idx] && idx < TLB_NUM) begin
      e.ppn0 = m_ppn0[idx];  e.flags0 = m_flags0[idx];
      e.ppn1 = m_ppn1[idx];  e.flags1 = m_flags1[idx];
      e.g    = m_g[idx];     e.vppn   = m_vppn[idx];
      e.ps   = m_ps[idx];    e.asid   = m_asid[idx];
    end else begin
      e.ne = 1'b1;
    end
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".ppn0"},   64'(TLB_PPN_0),   64'(e.ppn0));
    check({tag, ".flags0"}, 64'(TLB_flags_0), 64'(e.flags0));
    check({tag, ".g0"},     64'(TLB_G_0),     64'(e.g));
    check({tag, ".ppn1"},   64'(TLB_PPN_1),   64'(e.ppn1));
    check({tag, ".flags1"}, 64'(TLB_flags_1), 64'(e.flags1));
    check({tag, ".g1"},     64'(TLB_G_1),     64'(e.g));
    check({tag, ".vppn"},   64'(TLB_VPPN),    64'(e.vppn));
    check({tag, ".ps"},     64'(TLB_PS),      64'(e.ps));
    check({tag, ".asid"},   64'(TLB_ASID),    64'(e.asid));
    check({tag, ".ne"},     64'(TLB_NE),      64'(e.ne));
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (TLBRD_en || tlbrd_done)) begin
      check("done_eq_en", 64'(tlbrd_done), 64'(TLBRD_en));
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_cycle", 64'(cyc_cnt), 64'(e.cyc));
        check_fields("wb", e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after a posedge in an IDLE cycle; returns 1ns into the RD cycle.
  task automatic issue(input int idx, input bit expect_wb);
    exp_t e;
    tlbrd_req    = 1'b1;
    tlbidx_index = IDX_W'(idx);
    @(negedge clk);
    check("accept.rd_en",   64'(tlb_rd_en),   64'(1));
    check("accept.rd_addr", 64'(tlb_rd_addr), 64'(idx));
    check("accept.busy",    64'(tlbrd_busy),  64'(0));
    e     = make_exp(idx);
    e.cyc = cyc_cnt + 2;
    if (expect_wb) exp_q.push_back(e);
    tick(1);
    tlbrd_req = 1'b0;
  endtask

  initial begin
    exp_t zero;
    int   p0;
    zero = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      m_e[i] = 1'b1;                 m_vppn[i]   = 19'($urandom);
      m_ps[i] = 6'($urandom);        m_asid[i]   = 10'($urandom);
      m_g[i] = 1'($urandom);         m_ppn0[i]   = 20'($urandom) | 20'h1;
      m_flags0[i] = 6'($urandom);    m_ppn1[i]   = 20'($urandom) | 20'h2;
      m_flags1[i] = 6'($urandom);
    end
    m_vppn[5] = 19'h1234; m_ps[5] = 6'd12; m_asid[5] = 10'h3A; m_g[5] = 1'b1;
    m_ppn0[5] = 20'hABCDE; m_flags0[5] = 6'h2D; m_ppn1[5] = 20'h12345; m_flags1[5] = 6'h11;
    m_e[3] = 1'b0; m_vppn[3] = 19'h7FFFF; m_ps[3] = 6'h3F; m_asid[3] = 10'h3FF; m_g[3] = 1'b1;
    m_ppn0[3] = 20'hFFFFF; m_flags0[3] = 6'h3F; m_ppn1[3] = 20'hFFFFF; m_flags1[3] = 6'h3F;

    rst = 1'b1; tlbrd_req = 1'b0; flush = 1'b0; tlbidx_index = '0;
    tick(2);
    check("reset.busy",    64'(tlbrd_busy), 64'(0));
    check("reset.en",      64'(TLBRD_en),   64'(0));
    check("reset.rd_addr", 64'(tlb_rd_addr), 64'(0));
    check_fields("reset", zero);
    rst = 1'b0;
    tick(1);

    // Valid read with busy profile.
    issue(5, 1'b1);
    @(negedge clk); check("valid.busy_rd", 64'(tlbrd_busy), 64'(1));
    tick(1);
    @(negedge clk); check("valid.busy_wb", 64'(tlbrd_busy), 64'(1));
    tick(1);
    @(negedge clk); check("valid.busy_idle", 64'(tlbrd_busy), 64'(0));
    tick(1);

    // Invalid entry with junk fields.
    issue(3, 1'b1); tick(2);
    shadow = make_exp(3);

    // Flush in RD: nothing written, outputs hold.
    issue(5, 1'b0);
    flush = 1'b1;
    @(negedge clk); check("flush_rd.en", 64'(TLBRD_en), 64'(0));
    tick(1); flush = 1'b0;
    @(negedge clk);
    check("flush_rd.busy", 64'(tlbrd_busy), 64'(0));
    check_fields("flush_rd.hold", shadow);
    tick(1);

    // Flush in WB: strobe gated, capture still happened.
    issue(1, 1'b0); tick(1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_wb.en",   64'(TLBRD_en),   64'(0));
    check("flush_wb.done", 64'(tlbrd_done), 64'(0));
    tick(1); flush = 1'b0;
    @(negedge clk);
    check("flush_wb.busy", 64'(tlbrd_busy), 64'(0));
    check_fields("flush_wb.captured", make_exp(1));
    tick(1);

    // Request and flush together in IDLE.
    tlbrd_req = 1'b1; flush = 1'b1; tlbidx_index = 4'd5;
    @(negedge clk); check("req_flush.rd_en", 64'(tlb_rd_en), 64'(0));
    tick(1); tlbrd_req = 1'b0; flush = 1'b0;
    @(negedge clk); check("req_flush.busy", 64'(tlbrd_busy), 64'(0));
    tick(1);

    // Request held while busy: exactly one completion.
    p0 = pulses;
    issue(2, 1'b1);
    tlbrd_req = 1'b1; tlbidx_index = 4'd7;
    tick(2); tlbrd_req = 1'b0;
    tick(2);
    check("held_req.pulses", 64'(pulses - p0), 64'(1));

    // Back-to-back: strobes 3 cycles apart, checked via expected cycle.
    issue(1, 1'b1); tick(2);
    issue(2, 1'b1); tick(2);

    // Out-of-range and boundary indices.
    issue(14, 1'b1); tick(2);
    issue(12, 1'b1); tick(2);
    issue(11, 1'b1); tick(2);

    // Async reset in RD.
    issue(5, 1'b0);
    rst = 1'b1;
    #1;
    check("arst.busy",  64'(tlbrd_busy), 64'(0));
    check("arst.en",    64'(TLBRD_en),   64'(0));
    check("arst.rd_en", 64'(tlb_rd_en),  64'(0));
    check_fields("arst", zero);
    tick(2); rst = 1'b0;
    tick(4);
    check("arst.after_busy", 64'(tlbrd_busy), 64'(0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
